// File: rtl/ps2_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx : PS/2 device-to-host frame receiver.
//
// Both raw PS/2 lines are brought into the clk domain through 2-FF
// synchronizers. The clock line is then deglitched by a level filter. Each
// falling edge of the filtered clock samples one bit of an 11-bit frame:
// start(0), 8 data bits LSB first, odd parity, stop(1).
//
// An idle counter aborts a frame that stalls for TIMEOUT_CYC cycles.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   When defined, a frame with bad odd parity is rejected with err.
//   When undefined, the parity bit is shifted in but ignored.
//
// Parameters
//   FILT_LEN    consecutive equal samples needed to move the filtered clock
//   TIMEOUT_CYC cycles without a filtered edge inside a frame before abort
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   ps2_clk   in   raw PS/2 clock line (asynchronous)
//   ps2_data  in   raw PS/2 data line (asynchronous)
//   data      out  last good scan code, held between valid pulses
//   valid     out  one-cycle pulse when data was updated
//   err       out  one-cycle pulse when a frame was rejected or timed out
//   busy      out  high while a frame is in progress
// ----------------------------------------------------------------------------
module ps2_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0]     clk_sync_q;
  logic [1:0]     dat_sync_q;
  logic           filt_q, filt_d;
  logic           filt_prev_q;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           busy_q;

  logic           fall_s;
  logic           dat_s;
  logic           timeout_s;
  logic           parity_ok_s;
  logic           frame_good_s;

  assign dat_s  = dat_sync_q[1];
  assign fall_s = filt_prev_q & ~filt_q;

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign parity_ok_s = ^{shift_q, par_q};
`else
  logic unused_par_s;
  assign unused_par_s = par_q;
  assign parity_ok_s  = 1'b1;
`endif

  // In STOP the current sample is the stop bit itself.
  assign frame_good_s = dat_s & parity_ok_s;

  assign timeout_s = (state_q != S_IDLE) && (idle_cnt_q == TCW'(TIMEOUT_CYC));

  // Filter: flip the level after FILT_LEN consecutive samples at the other level.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
        filt_d     = ~filt_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  // Frame FSM, idle counter and output pulse generation.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    idle_cnt_d = idle_cnt_q;

    // Saturating; cleared by every edge, counts only inside a frame.
    if (fall_s) begin
      idle_cnt_d = '0;
    end else if ((state_q != S_IDLE) && (idle_cnt_q != TCW'(TIMEOUT_CYC))) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    // An edge takes priority over a coincident timeout.
    if (fall_s) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (frame_good_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_d   = S_IDLE;
      err_d     = 1'b1;
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end else begin
      state_d = state_q;
    end
  end

  // Synchronizers, filter and edge-detect history; reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      idle_cnt_q <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx : self-checking bench for ps2_rx.
// Drives PS/2 frames at a slow bit rate and compares pulse counts and the
// received code against a frame-level model of the protocol.
// ----------------------------------------------------------------------------
module tb_ps2_rx;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 5000;
  localparam int HALF        = 40;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       busy;

  int n_checks;
  int n_errors;
  int valid_cnt;
  int err_cnt;
  int both_cnt;
  int hold_viol;
  logic [7:0] data_last;
  logic [7:0] exp_data;
  bit         par_en;

  ps2_rx #(
    .FILT_LEN   (FILT_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data    (data),
    .valid   (valid),
    .err     (err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Pulse monitor, sampled 2 ns after the active edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (valid) valid_cnt++;
      if (err) err_cnt++;
      if (valid && err) both_cnt++;
      if (!valid && (data != data_last)) hold_viol++;
    end
    data_last = data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(FILT_LEN - 2);
      ps2_clk = 1'b1;
      wait_cyc(HALF - 10 - (FILT_LEN - 2));
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; a glitch is inserted before bit gl_idx.
  task automatic send_bits(input logic [7:0] b, input logic p, input logic s,
                           input int nbits, input int gl_idx);
    logic [10:0] bits;
    bits = {s, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_bit(bits[i], (i == gl_idx));
    end
    ps2_data = 1'b1;
  endtask

  // Full frame plus checks against the protocol model.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic p,
                           input logic s, input int gl_idx);
    int  v0;
    int  e0;
    bit  good;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(b, p, s, 11, gl_idx);
    wait_cyc(60);
    good = (s == 1'b1) && (!par_en || (($countones(b) + int'(p)) % 2 == 1));
    if (good) exp_data = b;
    check({tag, "_valid"}, valid_cnt - v0, good ? 1 : 0);
    check({tag, "_err"}, err_cnt - e0, good ? 0 : 1);
    check({tag, "_data"}, {24'h0, data}, {24'h0, exp_data});
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int v0;
    int e0;
    logic [7:0] rb;
    logic       rp;
    logic       rs;
    n_checks  = 0;
    n_errors  = 0;
    valid_cnt = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    hold_viol = 0;
    exp_data  = 8'h00;
`ifdef PS2_PARITY_CHECK_EN
    par_en = 1'b1;
`else
    par_en = 1'b0;
`endif
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Directed frames.
    run_frame("f1c", 8'h1C, 1'b0, 1'b1, -1);
    run_frame("ff0", 8'hF0, 1'b1, 1'b1, -1);
    run_frame("f1c_b", 8'h1C, 1'b0, 1'b1, -1);
    run_frame("f1c_badpar", 8'h1C, 1'b1, 1'b1, -1);
    run_frame("bad_stop", 8'h5A, 1'b1, 1'b0, -1);

    // Timeout after start + 4 data bits.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(8'h1C, 1'b0, 1'b1, 5, -1);
    wait_cyc(20);
    check("to_busy_mid", {31'h0, busy}, 32'h1);
    wait_cyc(TIMEOUT_CYC + 200);
    check("to_err", err_cnt - e0, 1);
    check("to_valid", valid_cnt - v0, 0);
    check("to_busy", {31'h0, busy}, 32'h0);
    run_frame("after_to", 8'h1C, 1'b0, 1'b1, -1);

    // Clock glitch shorter than the filter length.
    run_frame("glitch", 8'h1C, 1'b0, 1'b1, 4);

    // Reset mid-frame after the 5th data bit.
    e0 = err_cnt;
    send_bits(8'hF0, 1'b1, 1'b1, 6, -1);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    exp_data = 8'h00;
    check("mrst_data", {24'h0, data}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_valid", {31'h0, valid}, 32'h0);
    wait_cyc(TIMEOUT_CYC + 50);
    check("mrst_err", err_cnt - e0, 0);
    run_frame("after_rst", 8'hF0, 1'b1, 1'b1, -1);

    // Randomized frames: mostly correct parity, occasional bad stop.
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rp = (($countones(rb) % 2) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(3, 0) == 0) rp = ~rp;
      rs = ($urandom_range(4, 0) != 0) ? 1'b1 : 1'b0;
      run_frame($sformatf("rnd%0d", i), rb, rp, rs,
                ($urandom_range(2, 0) == 0) ? int'($urandom_range(10, 1)) : -1);
    end

    check("valid_err_excl", both_cnt, 0);
    check("data_hold", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
